// File: rtl/inst_encode_loader.sv
// Encodes symbolic instructions into 32-bit MIPS words and loads them into consecutive
// instruction-memory addresses, holding the CPU in run-inhibit until the load is done.
// Optional macro CHECKSUM_EN adds a running-XOR checksum output of all written words.
module inst_encode_loader #(
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_kind,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    input  logic                  in_last,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [INST_WIDTH-1:0] imem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  done,
    output logic [1:0]            err_code,
    output logic                  cpu_run
`ifdef CHECKSUM_EN
    ,
    output logic [INST_WIDTH-1:0] checksum
`endif
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(1) << ADDR_WIDTH;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_OVF     = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                    in_ready_q, in_ready_d;
    logic                    imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
    logic [INST_WIDTH-1:0]   imem_wdata_q, imem_wdata_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    done_q, done_d;
    logic [1:0]              err_q, err_d;
    logic                    cpu_run_q, cpu_run_d;
`ifdef CHECKSUM_EN
    logic [INST_WIDTH-1:0]   checksum_q, checksum_d;
`endif

    logic [5:0]  opcode_c;
    logic [5:0]  funct_c;
    logic        legal_c;
    logic [31:0] enc_c;
    logic        accept_c;

    // Instruction encoder: kinds 0-4 are R-type, 9 is j, the rest of 5-8 are I-type
    always_comb begin
        opcode_c = 6'h00;
        funct_c  = 6'h20;
        legal_c  = 1'b1;
        enc_c    = '0;
        case (in_kind)
            4'd0: funct_c = 6'h20;
            4'd1: funct_c = 6'h22;
            4'd2: funct_c = 6'h24;
            4'd3: funct_c = 6'h25;
            4'd4: funct_c = 6'h2A;
            4'd5: opcode_c = 6'h23;
            4'd6: opcode_c = 6'h2B;
            4'd7: opcode_c = 6'h08;
            4'd8: opcode_c = 6'h04;
            4'd9: opcode_c = 6'h02;
            default: legal_c = 1'b0;
        endcase
        if (in_kind <= 4'd4) begin
            enc_c = {6'h00, in_rs, in_rt, in_rd, 5'd0, funct_c};
        end else if (in_kind == 4'd9) begin
            enc_c = {opcode_c, in_target};
        end else begin
            enc_c = {opcode_c, in_rs, in_rt, in_imm};
        end
    end

    assign accept_c = in_valid & in_ready_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        count_d      = count_q;
        done_d       = done_q;
        err_d        = err_q;
`ifdef CHECKSUM_EN
        checksum_d   = checksum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d     = S_LOAD;
                    ptr_d       = BASE;
                    imem_addr_d = BASE;
                    count_d     = '0;
                    done_d      = 1'b0;
                    err_d       = ERR_NONE;
`ifdef CHECKSUM_EN
                    checksum_d  = '0;
`endif
                end
            end
            S_LOAD: begin
                if (accept_c) begin
                    if (!legal_c) begin
                        state_d = S_ERR;
                        err_d   = ERR_ILLEGAL;
                    end else begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = ptr_q;
                        imem_wdata_d = INST_WIDTH'(enc_c);
`ifdef CHECKSUM_EN
                        checksum_d   = checksum_q ^ INST_WIDTH'(enc_c);
`endif
                        if (count_q != CNT_MAX) begin
                            count_d = count_q + CNT_W'(1);
                        end
                        // The top address is written but never wraps; only in_last ends cleanly there
                        if (in_last) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else if (ptr_q == TOP_ADDR) begin
                            state_d = S_ERR;
                            err_d   = ERR_OVF;
                        end else begin
                            ptr_d = ptr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_LOAD);
        cpu_run_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= BASE;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE;
            imem_wdata_q <= '0;
            count_q      <= '0;
            done_q       <= 1'b0;
            err_q        <= ERR_NONE;
            cpu_run_q    <= 1'b0;
`ifdef CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            count_q      <= count_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cpu_run_q    <= cpu_run_d;
`ifdef CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign count      = count_q;
    assign done       = done_q;
    assign err_code   = err_q;
    assign cpu_run    = cpu_run_q;
`ifdef CHECKSUM_EN
    assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_inst_encode_loader.sv
// Bench for inst_encode_loader: a default-size loader and a 4-word loader share one stimulus
// stream and are checked every cycle against a transaction-level model. Honours CHECKSUM_EN.
module tb_inst_encode_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_kind = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        in_last = 1'b0;

    logic        rdy0, rdy1, we0, we1, done0, done1, run0, run1;
    logic [5:0]  addr0;
    logic [1:0]  addr1;
    logic [31:0] wd0, wd1;
    logic [6:0]  cnt0;
    logic [2:0]  cnt1;
    logic [1:0]  err0, err1;
`ifdef CHECKSUM_EN
    logic [31:0] cs0, cs1;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    inst_encode_loader dut0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy0),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .imem_we(we0), .imem_addr(addr0),
        .imem_wdata(wd0), .count(cnt0), .done(done0), .err_code(err0), .cpu_run(run0)
`ifdef CHECKSUM_EN
        , .checksum(cs0)
`endif
    );

    inst_encode_loader #(.ADDR_WIDTH(2)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy1),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .imem_we(we1), .imem_addr(addr1),
        .imem_wdata(wd1), .count(cnt1), .done(done1), .err_code(err1), .cpu_run(run1)
`ifdef CHECKSUM_EN
        , .checksum(cs1)
`endif
    );

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Word built from field arithmetic on the MIPS layout
    function automatic logic [31:0] m_enc(input int k, input int rs, input int rt, input int rd,
                                          input int imm, input int tgt);
        longint w;
        case (k)
            0: w = 32'h20;
            1: w = 32'h22;
            2: w = 32'h24;
            3: w = 32'h25;
            4: w = 32'h2A;
            5: w = longint'(35) * 2**26;
            6: w = longint'(43) * 2**26;
            7: w = longint'(8) * 2**26;
            8: w = longint'(4) * 2**26;
            default: w = longint'(2) * 2**26;
        endcase
        if (k == 9) w = w + tgt;
        else if (k <= 4) w = w + rs * 2**21 + rt * 2**16 + rd * 2**11;
        else w = w + rs * 2**21 + rt * 2**16 + imm;
        return w[31:0];
    endfunction

    // Model: phase 0 idle, 1 loading, 2 finished, 3 failed
    int          m_aw[2] = '{6, 2};
    int          m_ph[2], m_ptr[2], m_addr[2], m_cnt[2], m_err[2];
    bit          m_we[2], m_done[2];
    logic [31:0] m_wd[2], m_cs[2];

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_ph[d] = 0; m_ptr[d] = 0; m_addr[d] = 0; m_cnt[d] = 0; m_err[d] = 0;
                m_we[d] = 0; m_done[d] = 0; m_wd[d] = '0; m_cs[d] = '0;
            end else begin
                m_we[d] = 0;
                if (m_ph[d] != 1 && start) begin
                    m_ph[d] = 1; m_ptr[d] = 0; m_addr[d] = 0; m_cnt[d] = 0;
                    m_err[d] = 0; m_done[d] = 0; m_cs[d] = '0;
                end else if (m_ph[d] == 1 && in_valid) begin
                    if (int'(in_kind) > 9) begin
                        m_ph[d] = 3; m_err[d] = 1;
                    end else begin
                        m_wd[d] = m_enc(int'(in_kind), int'(in_rs), int'(in_rt), int'(in_rd),
                                        int'(in_imm), int'(in_target));
                        m_we[d] = 1;
                        m_addr[d] = m_ptr[d];
                        m_cs[d] = m_cs[d] ^ m_wd[d];
                        if (m_cnt[d] < 2**m_aw[d]) m_cnt[d]++;
                        if (in_last) begin
                            m_ph[d] = 2; m_done[d] = 1;
                        end else if (m_ptr[d] == 2**m_aw[d] - 1) begin
                            m_ph[d] = 3; m_err[d] = 2;
                        end else begin
                            m_ptr[d]++;
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison of both loaders against the model
    always @(negedge clk) begin
        chk("in_ready", 0, rdy0, m_ph[0] == 1);
        chk("imem_we", 0, we0, m_we[0]);
        chk("imem_addr", 0, addr0, m_addr[0]);
        chk("imem_wdata", 0, wd0, m_wd[0]);
        chk("count", 0, cnt0, m_cnt[0]);
        chk("done", 0, done0, m_done[0]);
        chk("err_code", 0, err0, m_err[0]);
        chk("cpu_run", 0, run0, m_ph[0] == 2);
        chk("in_ready", 1, rdy1, m_ph[1] == 1);
        chk("imem_we", 1, we1, m_we[1]);
        chk("imem_addr", 1, addr1, m_addr[1]);
        chk("imem_wdata", 1, wd1, m_wd[1]);
        chk("count", 1, cnt1, m_cnt[1]);
        chk("done", 1, done1, m_done[1]);
        chk("err_code", 1, err1, m_err[1]);
        chk("cpu_run", 1, run1, m_ph[1] == 2);
`ifdef CHECKSUM_EN
        chk("checksum", 0, cs0, m_cs[0]);
        chk("checksum", 1, cs1, m_cs[1]);
`endif
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one beat and returns on the falling edge after dut0 accepts it
    task automatic beat(input int k, input int rs, input int rt, input int rd, input int imm,
                        input int tgt, input bit last);
        bit ok = 0;
        bit r;
        in_kind = 4'(k); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_imm = 16'(imm); in_target = 26'(tgt); in_last = last; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r = rdy0;
            @(negedge clk);
            if (r) begin
                ok = 1;
                break;
            end
        end
        chk("beat_accept", 0, ok, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 0, rdy0, 0);
        chk("rst_run", 0, run0, 0);
        chk("rst_addr", 0, addr0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single R-type program
        do_start();
        beat(0, 1, 2, 3, 0, 0, 1);
        chk("add_word", 0, wd0, 32'h00221820);
        chk("add_addr", 0, addr0, 0);
        chk("add_we", 0, we0, 1);
        chk("add_done", 0, done0, 1);
        chk("add_run", 0, run0, 1);
        chk("add_count", 0, cnt0, 1);
        idle(1);
        chk("add_we_drop", 0, we0, 0);

        // Back-to-back I-type and jump, with a start pulse ignored mid-load
        do_start();
        beat(5, 1, 2, 0, 4, 0, 0);
        chk("lw_word", 0, wd0, 32'h8C220004);
        start = 1'b1;
        beat(6, 1, 2, 0, 8, 0, 0);
        start = 1'b0;
        chk("sw_word", 0, wd0, 32'hAC220008);
        chk("sw_addr", 0, addr0, 1);
        beat(7, 0, 1, 0, 5, 0, 0);
        chk("addi_word", 0, wd0, 32'h20010005);
        beat(8, 1, 2, 0, 16'hFFFF, 0, 0);
        chk("beq_word", 0, wd0, 32'h1022FFFF);
        chk("beq_addr", 0, addr0, 3);
        chk("small_ovf_err", 1, err1, 2);
        chk("small_ovf_count", 1, cnt1, 4);
        beat(9, 0, 0, 0, 0, 26'h10, 1);
        chk("j_word", 0, wd0, 32'h08000010);
        chk("j_addr", 0, addr0, 4);
        chk("j_count", 0, cnt0, 5);
        chk("j_done", 0, done0, 1);
        chk("small_no_fifth", 1, we1, 0);
`ifdef CHECKSUM_EN
        chk("checksum_lit", 0, cs0, 32'h1823FFE6);
`endif
        idle(1);

        // Overflow on the 4-word loader while the large one keeps loading
        do_start();
        for (int i = 0; i < 4; i++) beat(1, i, i + 1, i + 2, 0, 0, 0);
        idle(1);
        chk("ovf_err", 1, err1, 2);
        chk("ovf_count", 1, cnt1, 4);
        chk("ovf_ready", 1, rdy1, 0);
        beat(3, 7, 8, 9, 0, 0, 1);
        chk("ovf_big_count", 0, cnt0, 5);
        idle(1);

        // Top address with in_last finishes cleanly
        do_start();
        for (int i = 0; i < 3; i++) beat(2, 3, 4, 5, 0, 0, 0);
        beat(7, 1, 1, 0, 16'h7FFF, 0, 1);
        chk("top_last_done", 1, done1, 1);
        chk("top_last_err", 1, err1, 0);
        chk("top_last_addr", 1, addr1, 3);
        idle(1);

        // Illegal kind with in_last: error wins, then restart
        do_start();
        beat(0, 4, 5, 6, 0, 0, 0);
        beat(12, 1, 2, 3, 0, 0, 1);
        chk("ill_err", 0, err0, 1);
        chk("ill_we", 0, we0, 0);
        chk("ill_count", 0, cnt0, 1);
        chk("ill_done", 0, done0, 0);
        idle(1);
        chk("ill_ready", 0, rdy0, 0);
        do_start();
        chk("restart_ready", 0, rdy0, 1);
        chk("restart_addr", 0, addr0, 0);
        chk("restart_err", 0, err0, 0);

        // Gapped valid, then asynchronous reset mid-load
        beat(4, 1, 2, 4, 0, 0, 0);
        chk("slt_word", 0, wd0, 32'h0022202A);
        idle(1);
        chk("gap_we", 0, we0, 0);
        beat(4, 1, 2, 4, 0, 0, 0);
        chk("slt2_addr", 0, addr0, 1);
        idle(1);
        beat(4, 1, 2, 4, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", 0, rdy0, 0);
        chk("arst_count", 0, cnt0, 0);
        chk("arst_wdata", 0, wd0, 0);
        chk("arst_addr", 0, addr0, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        do_start();
        beat(9, 0, 0, 0, 0, 26'h3FFFFFF, 1);
        chk("post_rst_word", 0, wd0, 32'h0BFFFFFF);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_encode_loader.md
Name: inst_encode_loader

Overview:
Encoder counterpart of the instruction decoder. Accepts symbolic instructions (kind plus register/immediate fields) over a valid/ready stream and encodes each into a 32-bit MIPS word. Writes the words to consecutive instruction-memory addresses. Holds the CPU in run-inhibit until the program load completes, so it sits between the test/boot source and instruction memory.

Parameters:
INST_WIDTH, 32, instruction word width (fixed 32 for encoding)
ADDR_WIDTH, 6, instruction-memory word-address width
BASE_ADDR, 0, first word address written after start

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  begin new load (honoured in IDLE, DONE, ERR; ignored in LOAD)
in_valid  input  1  instruction beat valid
in_ready  output  1  block can accept beat
in_kind  input  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lw, 6 sw, 7 addi, 8 beq, 9 j, 10-15 illegal
in_rs  input  5  source register
in_rt  input  5  target register
in_rd  input  5  destination register (R-type only)
in_imm  input  16  immediate/offset (lw, sw, addi, beq)
in_target  input  26  jump target (j)
in_last  input  1  final beat of program
imem_we  output  1  instruction-memory write strobe
imem_addr  output  ADDR_WIDTH  write address
imem_wdata  output  INST_WIDTH  encoded word
count  output  ADDR_WIDTH+1  words written since start
done  output  1  load complete
err_code  output  2  0 none, 1 illegal kind, 2 overflow
cpu_run  output  1  high only in DONE

Behaviour:
- Reset (async): state IDLE, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, done=0, err_code=0, cpu_run=0. A reset mid-load abandons the load; memory contents are not restored.
- FSM states: IDLE, LOAD, DONE, ERR.
  - IDLE/DONE/ERR + start -> LOAD; clears count, done, err_code; next write address = BASE_ADDR.
- in_ready = 1 only in LOAD. Beat accepted on a rising edge with in_valid & in_ready. in_valid with in_ready low is held by the source; no beat is lost.
- Latency: one cycle. An accepted legal beat produces imem_we=1 for exactly one cycle on the next cycle, with registered imem_addr/imem_wdata. The address then increments. Back-to-back beats give one write per cycle.
- Encoding:
  - R-type: op=0, rs[25:21], rt[20:16], rd[15:11], shamt=0; funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - I-type: lw op 0x23, sw 0x2B, addi 0x08, beq 0x04; fields rs, rt, imm[15:0]. in_rd is ignored.
  - j: op 0x02, target[25:0]; register fields are ignored.
- Illegal kind (10-15): no write. State goes to ERR with err_code=1, and count is unchanged.
- in_last on a legal beat: the word is written, then state goes to DONE with done=1 and cpu_run=1, asserted in the same cycle as the final imem_we.
- Overflow: a legal beat accepted at the top address (2^ADDR_WIDTH-1) with in_last=0 is still written, then state goes to ERR with err_code=2. The address never wraps. A top-address beat with in_last=1 goes to DONE normally.
- Illegal kind with in_last=1: ERR takes priority.
- count increments once per write and saturates at 2^ADDR_WIDTH.
- DONE/ERR hold their outputs until start or rst.

Optional Feature:
CHECKSUM_EN
- Defined: adds output port checksum [INST_WIDTH-1:0], a running XOR of every word written since start. It is cleared on start and on rst, updates in the same cycle as imem_we, and is valid with done.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- rst, start, beat kind=0 rs=1 rt=2 rd=3 last=1 -> next cycle imem_we=1, addr=0, wdata=0x00221820, done=1, cpu_run=1, count=1.
- start, back-to-back beats: lw rs=1 rt=2 imm=4; sw rs=1 rt=2 imm=8; addi rs=0 rt=1 imm=5; beq rs=1 rt=2 imm=0xFFFF; j target=0x10 last=1 -> writes 0x8C220004, 0xAC220008, 0x20010005, 0x1022FFFF, 0x08000010 at addrs 0-4 on consecutive cycles; count=5. With CHECKSUM_EN, checksum = XOR of those five words.
- Beat kind=12 at second position -> no write for it, err_code=1, in_ready=0, count=1. A later start recovers to LOAD with addr=0.
- ADDR_WIDTH=2, four legal beats with last=0 -> writes at addr 0-3, then ERR err_code=2, count=4, no fifth write.
- in_valid toggled 1/0 with slt rs=1 rt=2 rd=4 -> only handshaken beats are written (0x0022202A). rst asserted mid-load -> all outputs return to reset values immediately, asynchronously.
